alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_mc.sv | 171 +++++++++++++++++
 tb/tb_alu_mc.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU. Most modes finish in one cycle; unsigned multiply
// and divide iterate one bit per cycle. The adder is a ripple of 4-bit CLA groups.

// One 4-bit carry-lookahead group.
module cla4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [3:0] g, p;
  logic [3:0] c;
  assign g = x & y;
  assign p = x ^ y;
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);
  assign s = p ^ c;
endmodule

module alu_mc #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [4:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_hi,
  output logic             cout,
  output logic             ovf,
  output logic             dz
);
  localparam int NG = WIDTH / 4;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nx;

  logic accept;
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;

  // Shared adder: a+b+cin for mode 4, a-b for modes 5 and 13.
  logic [WIDTH-1:0] add_y, add_s;
  logic [NG:0]      gc;
  logic             add_ovf, slt;
  assign add_y = (mode == 5'd4) ? b : ~b;
  assign gc[0] = (mode == 5'd4) ? cin : 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < NG; gi++) begin : g_cla
      cla4 u_cla (
        .x  (a[gi*4 +: 4]),
        .y  (add_y[gi*4 +: 4]),
        .ci (gc[gi]),
        .s  (add_s[gi*4 +: 4]),
        .co (gc[gi+1])
      );
    end
  endgenerate

  assign add_ovf = (a[WIDTH-1] == add_y[WIDTH-1]) & (add_s[WIDTH-1] != a[WIDTH-1]);
  assign slt     = add_s[WIDTH-1] ^ add_ovf;

  // Single-cycle result selection (also covers divide-by-zero).
  logic [WIDTH-1:0] sc_y, sc_yhi, msb_idx;
  logic             sc_cout, sc_ovf, sc_dz;
  always_comb begin
    msb_idx = '0;
    for (int i = 0; i < WIDTH; i++)
      if (a[i]) msb_idx = WIDTH'(i);
    sc_y    = '0;
    sc_yhi  = '0;
    sc_cout = 1'b0;
    sc_ovf  = 1'b0;
    sc_dz   = 1'b0;
    case (mode)
      5'd0, 5'd1: sc_y = a << 1;
      5'd2:       sc_y = a >> 1;
      5'd3:       sc_y = {a[WIDTH-1], a[WIDTH-1:1]};
      5'd4, 5'd5: begin sc_y = add_s; sc_cout = gc[NG]; sc_ovf = add_ovf; end
      5'd6:       sc_y = a & b;
      5'd7:       sc_y = a | b;
      5'd8:       sc_y = ~a;
      5'd9:       sc_y = a ^ b;
      5'd10:      sc_y = ~(a ^ b);
      5'd11:      sc_y = ~(a | b);
      5'd12:      sc_y = WIDTH'(1) << a[3:0];
      5'd13:      begin sc_y = WIDTH'(slt); sc_cout = gc[NG]; sc_ovf = add_ovf; end
      5'd14:      sc_y = b;
      5'd15:      sc_y = msb_idx;
      5'd17:      begin sc_y = '1; sc_yhi = a; sc_dz = 1'b1; end
      default:    ;
    endcase
  end

  // Iteration registers: p_hi/p_lo hold product or remainder/quotient.
  logic [WIDTH-1:0] op_r, p_hi, p_lo, hi_nx, lo_nx;
  logic             div_r;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   mul_sum, div_rem, div_sub;

  // One shift-add or restoring-divide step per CALC cycle.
  always_comb begin
    mul_sum = {1'b0, p_hi} + (p_lo[0] ? {1'b0, op_r} : '0);
    div_rem = {p_hi, p_lo[WIDTH-1]};
    div_sub = div_rem - {1'b0, op_r};
    if (div_r) begin
      hi_nx = div_sub[WIDTH] ? div_rem[WIDTH-1:0] : div_sub[WIDTH-1:0];
      lo_nx = {p_lo[WIDTH-2:0], ~div_sub[WIDTH]};
    end else begin
      hi_nx = mul_sum[WIDTH:1];
      lo_nx = {mul_sum[0], p_lo[WIDTH-1:1]};
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;

  // Next state: mul and nonzero divide go through CALC.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_valid)
              state_nx = ((mode == 5'd16) || (mode == 5'd17 && b != '0)) ? CALC : DONE;
      CALC: if (cnt == CW'(WIDTH-1)) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, iteration and result registers; results only change on completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r <= '0; p_hi <= '0; p_lo <= '0; div_r <= 1'b0; cnt <= '0;
      y <= '0; y_hi <= '0; cout <= 1'b0; ovf <= 1'b0; dz <= 1'b0;
    end else if (accept) begin
      op_r  <= (mode == 5'd16) ? a : b;
      p_lo  <= (mode == 5'd16) ? b : a;
      p_hi  <= '0;
      div_r <= (mode == 5'd17);
      cnt   <= '0;
      if (state_nx == DONE) begin
        y <= sc_y; y_hi <= sc_yhi; cout <= sc_cout; ovf <= sc_ovf; dz <= sc_dz;
      end
    end else if (state == CALC) begin
      p_hi <= hi_nx;
      p_lo <= lo_nx;
      cnt  <= cnt + 1'b1;
      if (cnt == CW'(WIDTH-1)) begin
        y <= lo_nx; y_hi <= hi_nx; cout <= 1'b0; dz <= 1'b0;
        ovf <= ~div_r & (hi_nx != '0);
      end
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc (WIDTH=16): directed vector table, handshake/reset
// sequences, and randomized ops against an arithmetic reference model.
module tb_alu_mc;
  logic        clk, rst, in_valid, in_ready, cin, out_valid, out_ready;
  logic [15:0] a, b, y, y_hi;
  logic [4:0]  mode;
  logic        cout, ovf, dz;

  int n_pass = 0, n_chk = 0;

  alu_mc #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .mode(mode), .out_valid(out_valid),
    .out_ready(out_ready), .y(y), .y_hi(y_hi), .cout(cout), .ovf(ovf), .dz(dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] y, yh;
    logic        c, o, d;
    int          lat;
  } res_t;

  typedef struct {
    logic [4:0]  m;
    logic [15:0] a, b;
    logic        ci;
    res_t        e;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model from the operation definitions.
  function automatic res_t ref_op(input logic [4:0] m, input logic [15:0] ia, ib, input logic ic);
    res_t r;
    logic [16:0] s;
    logic [31:0] p;
    logic signed [15:0] sa;
    int sr;
    r = '{16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1};
    sa = ia;
    case (m)
      0, 1: r.y = ia << 1;
      2:    r.y = ia >> 1;
      3:    r.y = 16'(sa >>> 1);
      4: begin
        s = {1'b0, ia} + {1'b0, ib} + 17'(ic);
        sr = int'($signed(ia)) + int'($signed(ib)) + int'(ic);
        r.y = s[15:0]; r.c = s[16]; r.o = (sr > 32767) || (sr < -32768);
      end
      5, 13: begin
        s = {1'b0, ia} + {1'b0, ~ib} + 17'd1;
        sr = int'($signed(ia)) - int'($signed(ib));
        r.c = s[16]; r.o = (sr > 32767) || (sr < -32768);
        r.y = (m == 5) ? s[15:0] : (($signed(ia) < $signed(ib)) ? 16'd1 : 16'd0);
      end
      6:  r.y = ia & ib;
      7:  r.y = ia | ib;
      8:  r.y = ~ia;
      9:  r.y = ia ^ ib;
      10: r.y = ~(ia ^ ib);
      11: r.y = ~(ia | ib);
      12: r.y = 16'd1 << ia[3:0];
      14: r.y = ib;
      15: for (int i = 0; i < 16; i++) if (ia[i]) r.y = 16'(i);
      16: begin
        p = 32'(ia) * 32'(ib);
        r.y = p[15:0]; r.yh = p[31:16]; r.o = (p[31:16] != 0); r.lat = 17;
      end
      17: if (ib == 0) begin
            r.y = 16'hFFFF; r.yh = ia; r.d = 1'b1;
          end else begin
            r.y = ia / ib; r.yh = ia % ib; r.lat = 17;
          end
      default: ;
    endcase
    return r;
  endfunction

  // Issue one op from a negedge, scramble inputs after accept, wait for result, retire it.
  task automatic run_op(input logic [4:0] m, input logic [15:0] ia, ib, input logic ic, output res_t r);
    int k;
    k = 0;
    while (!in_ready && k < 50) begin @(negedge clk); k++; end
    mode = m; a = ia; b = ib; cin = ic; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); mode = 5'($urandom);
    r.lat = 1;
    while (!out_valid && r.lat < 100) begin @(negedge clk); r.lat++; end
    r.y = y; r.yh = y_hi; r.c = cout; r.o = ovf; r.d = dz;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic cmp(input string name, input res_t r, input res_t e);
    chk({name, ".res"}, {r.y, r.yh, r.c, r.o, r.d}, {e.y, e.yh, e.c, e.o, e.d});
    chk({name, ".lat"}, 64'(r.lat), 64'(e.lat));
  endtask

  vec_t vt[14];
  res_t r, e;

  initial begin
    vt[0]  = '{5'd4,  16'h7FFF, 16'h0001, 1'b0, '{16'h8000, 16'h0000, 1'b0, 1'b1, 1'b0, 1}};
    vt[1]  = '{5'd5,  16'h0003, 16'h0005, 1'b0, '{16'hFFFE, 16'h0000, 1'b0, 1'b0, 1'b0, 1}};
    vt[2]  = '{5'd13, 16'h0003, 16'h0005, 1'b0, '{16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0, 1}};
    vt[3]  = '{5'd16, 16'hFFFF, 16'hFFFF, 1'b0, '{16'h0001, 16'hFFFE, 1'b0, 1'b1, 1'b0, 17}};
    vt[4]  = '{5'd17, 16'd100,  16'd7,    1'b0, '{16'd14,   16'd2,    1'b0, 1'b0, 1'b0, 17}};
    vt[5]  = '{5'd17, 16'd100,  16'd0,    1'b0, '{16'hFFFF, 16'd100,  1'b0, 1'b0, 1'b1, 1}};
    vt[6]  = '{5'd15, 16'h0120, 16'h0000, 1'b0, '{16'd8,    16'h0000, 1'b0, 1'b0, 1'b0, 1}};
    vt[7]  = '{5'd12, 16'h000F, 16'h0000, 1'b0, '{16'h8000, 16'h0000, 1'b0, 1'b0, 1'b0, 1}};
    vt[8]  = '{5'd3,  16'h8002, 16'h0000, 1'b0, '{16'hC001, 16'h0000, 1'b0, 1'b0, 1'b0, 1}};
    vt[9]  = '{5'd4,  16'hFFFF, 16'h0000, 1'b1, '{16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1}};
    vt[10] = '{5'd25, 16'h1234, 16'h5678, 1'b1, '{16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1}};
    vt[11] = '{5'd15, 16'h0000, 16'h0000, 1'b0, '{16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1}};
    vt[12] = '{5'd13, 16'h8000, 16'h7FFF, 1'b0, '{16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 1}};
    vt[13] = '{5'd0,  16'h8001, 16'h0000, 1'b0, '{16'h0002, 16'h0000, 1'b0, 1'b0, 1'b0, 1}};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; mode = '0;
    #1;
    chk("reset", {y, y_hi, cout, ovf, dz, out_valid, in_ready}, {16'h0, 16'h0, 5'b00001});
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed table
    foreach (vt[i]) begin
      run_op(vt[i].m, vt[i].a, vt[i].b, vt[i].ci, r);
      cmp($sformatf("vec%0d", i), r, vt[i].e);
    end

    // Back-pressure hold with an ignored second request
    mode = 5'd15; a = 16'h0120; b = '0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mode = 5'd4; a = 16'h0001; b = 16'h0001;
    chk("hold.first", {out_valid, in_ready, y}, {2'b10, 16'd8});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("hold.c%0d", i), {out_valid, in_ready, y, y_hi, cout, ovf, dz},
          {2'b10, 16'd8, 16'd0, 3'b000});
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("hold.release", {out_valid, in_ready}, 2'b01);
    @(negedge clk);
    chk("hold.notqueued", {out_valid, in_ready}, 2'b01);

    // Reset in the 8th CALC cycle of a multiply
    run_op(5'd9, 16'hF0F0, 16'h0FF0, 1'b0, r);
    cmp("pre_rst", r, ref_op(5'd9, 16'hF0F0, 16'h0FF0, 1'b0));
    mode = 5'd16; a = 16'h1234; b = 16'h5678; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("mul.in_calc", {out_valid, in_ready}, 2'b00);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst", {y, y_hi, cout, ovf, dz, out_valid, in_ready}, {16'h0, 16'h0, 5'b00001});
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst.release", {out_valid, in_ready}, 2'b01);
    run_op(5'd9, 16'h00FF, 16'h0F0F, 1'b0, r);
    cmp("post_rst", r, ref_op(5'd9, 16'h00FF, 16'h0F0F, 1'b0));

    // Randomized ops against the model
    for (int i = 0; i < 40; i++) begin
      logic [4:0]  m;
      logic [15:0] ra, rb;
      logic        rc;
      m  = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) m = 5'(16 + $urandom_range(0, 1));
      ra = 16'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      rc = 1'($urandom);
      e = ref_op(m, ra, rb, rc);
      run_op(m, ra, rb, rc, r);
      cmp($sformatf("rnd%0d.m%0d", i, m), r, e);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
